// File: rtl/date_display_seq.sv
`default_nettype none
// ============================================================================
// Module   : date_display_seq
// Purpose  : Steps through NUM_DATES stored BCD dates (MMDDYY) on six
//            seven-segment digits, with debounced next/prev keys, timed
//            auto-advance and a blank gap after every index change.
// Revision : 1.0 - initial release
// ============================================================================
module date_display_seq #(
    parameter int                      NUM_DATES      = 4,
    parameter logic [24*NUM_DATES-1:0] DATES          = {24'h051800, 24'h030170,
                                                         24'h123199, 24'h070400},
    parameter int                      TICKS_PER_STEP = 50000000,
    parameter int                      DEBOUNCE_TICKS = 500000,
    parameter int                      BLANK_TICKS    = 5000000
) (
    input  logic                 MAX10_CLK1_50,
    input  logic                 RST,
    input  logic [1:0]           KEY,
    input  logic [1:0]           SW,
    output logic [7:0]           HEX0,
    output logic [7:0]           HEX1,
    output logic [7:0]           HEX2,
    output logic [7:0]           HEX3,
    output logic [7:0]           HEX4,
    output logic [7:0]           HEX5,
    output logic [NUM_DATES-1:0] LEDR
);

    localparam int IDX_W = $clog2(NUM_DATES);
    localparam int AC_W  = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
    localparam int DB_W  = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
    localparam int BK_W  = (BLANK_TICKS > 1)    ? $clog2(BLANK_TICKS)    : 1;

    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_DATES - 1);
    localparam logic [AC_W-1:0]      AC_LAST  = AC_W'(TICKS_PER_STEP - 1);
    localparam logic [DB_W-1:0]      DB_LAST  = DB_W'(DEBOUNCE_TICKS - 1);
    localparam logic [BK_W-1:0]      BK_LAST  = BK_W'(BLANK_TICKS - 1);
    localparam logic [NUM_DATES-1:0] ONE_HOT0 = NUM_DATES'(1);

    wire clk = MAX10_CLK1_50;

    typedef enum logic [0:0] {
        SHOW  = 1'b0,
        BLANK = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Key conditioning: synchronise, debounce, pulse on debounced press
    // ------------------------------------------------------------------
    logic [1:0] press;

    genvar k;
    generate
        for (k = 0; k < 2; k++) begin : g_key
            logic            sync1;
            logic            sync2;
            logic            level;
            logic            pulse;
            logic [DB_W-1:0] cnt;

            always_ff @(posedge clk) begin
                if (RST) begin
                    sync1 <= 1'b1;
                    sync2 <= 1'b1;
                    level <= 1'b1;
                    pulse <= 1'b0;
                    cnt   <= '0;
                end else begin
                    sync1 <= KEY[k];
                    sync2 <= sync1;
                    pulse <= 1'b0;
                    if (sync2 != level) begin
                        if (cnt == DB_LAST) begin
                            level <= sync2;
                            cnt   <= '0;
                            pulse <= ~sync2;
                        end else begin
                            cnt <= cnt + DB_W'(1);
                        end
                    end else begin
                        cnt <= '0;
                    end
                end
            end

            assign press[k] = pulse;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Date table, entry 0 in the most-significant bits
    // ------------------------------------------------------------------
    logic [23:0] date_tab [NUM_DATES];

    genvar d;
    generate
        for (d = 0; d < NUM_DATES; d++) begin : g_tab
            assign date_tab[d] = DATES[24*(NUM_DATES-1-d) +: 24];
        end
    endgenerate

    function automatic logic [7:0] seg7(input logic [3:0] nib, input logic dp_on);
        logic [7:0] code;
        case (nib)
            4'd0:    code = 8'hC0;
            4'd1:    code = 8'hF9;
            4'd2:    code = 8'hA4;
            4'd3:    code = 8'hB0;
            4'd4:    code = 8'h99;
            4'd5:    code = 8'h92;
            4'd6:    code = 8'h82;
            4'd7:    code = 8'hF8;
            4'd8:    code = 8'h80;
            4'd9:    code = 8'h90;
            default: code = 8'hBF;
        endcase
        return dp_on ? (code & 8'h7F) : code;
    endfunction

    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] i);
        return (i == LAST_IDX) ? '0 : i + IDX_W'(1);
    endfunction

    function automatic logic [IDX_W-1:0] idx_dec(input logic [IDX_W-1:0] i);
        return (i == '0) ? LAST_IDX : i - IDX_W'(1);
    endfunction

    // ------------------------------------------------------------------
    // Index selection
    // ------------------------------------------------------------------
    state_t           state;
    logic [IDX_W-1:0] index;
    logic [AC_W-1:0]  auto_cnt;
    logic [BK_W-1:0]  blank_cnt;

    logic [IDX_W-1:0] idx_next;
    logic             idx_change;
    logic             auto_clr;
    logic [23:0]      cur_date;

    always_comb begin
        idx_next   = index;
        idx_change = 1'b0;
        auto_clr   = 1'b0;
        if (press[1] && press[0]) begin
            auto_clr = 1'b1;
        end else if (press[1]) begin
            idx_next   = idx_inc(index);
            idx_change = 1'b1;
        end else if (press[0]) begin
            idx_next   = idx_dec(index);
            idx_change = 1'b1;
        end else if (SW[0] && auto_cnt == AC_LAST) begin
            idx_next   = SW[1] ? idx_dec(index) : idx_inc(index);
            idx_change = 1'b1;
        end
    end

    assign cur_date = date_tab[index];

    // ------------------------------------------------------------------
    // Sequencer and registered outputs (outputs follow state one cycle late)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (RST) begin
            state     <= SHOW;
            index     <= '0;
            auto_cnt  <= '0;
            blank_cnt <= '0;
            HEX0      <= 8'hFF;
            HEX1      <= 8'hFF;
            HEX2      <= 8'hFF;
            HEX3      <= 8'hFF;
            HEX4      <= 8'hFF;
            HEX5      <= 8'hFF;
            LEDR      <= ONE_HOT0;
        end else begin
            index <= idx_next;

            if (idx_change || auto_clr || !SW[0]) begin
                auto_cnt <= '0;
            end else begin
                auto_cnt <= auto_cnt + AC_W'(1);
            end

            case (state)
                SHOW: begin
                    blank_cnt <= '0;
                    if (idx_change) begin
                        state <= BLANK;
                    end
                end
                BLANK: begin
                    if (idx_change) begin
                        blank_cnt <= '0;
                    end else if (blank_cnt == BK_LAST) begin
                        blank_cnt <= '0;
                        state     <= SHOW;
                    end else begin
                        blank_cnt <= blank_cnt + BK_W'(1);
                    end
                end
                default: begin
                    state     <= SHOW;
                    blank_cnt <= '0;
                end
            endcase

            if (state == SHOW) begin
                HEX5 <= seg7(cur_date[23:20], 1'b0);
                HEX4 <= seg7(cur_date[19:16], 1'b1);
                HEX3 <= seg7(cur_date[15:12], 1'b0);
                HEX2 <= seg7(cur_date[11:8],  1'b1);
                HEX1 <= seg7(cur_date[7:4],   1'b0);
                HEX0 <= seg7(cur_date[3:0],   1'b0);
            end else begin
                HEX5 <= 8'hFF;
                HEX4 <= 8'hFF;
                HEX3 <= 8'hFF;
                HEX2 <= 8'hFF;
                HEX1 <= 8'hFF;
                HEX0 <= 8'hFF;
            end

            LEDR <= ONE_HOT0 << index;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_date_display_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_date_display_seq
// Purpose  : Directed self-checking bench for date_display_seq.
// Revision : 1.0 - initial release
// ============================================================================
module tb_date_display_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] key;
    logic [1:0] sw;

    logic [7:0] h0, h1, h2, h3, h4, h5;
    logic [7:0] a0, a1, a2, a3, a4, a5;
    logic [2:0] ledr;
    logic [2:0] ledr_a;

    int checks = 0;
    int errors = 0;

    localparam logic [47:0] D0  = {8'hC0, 8'h12, 8'hF9, 8'h00, 8'hC0, 8'hC0};
    localparam logic [47:0] D1  = {8'hC0, 8'h30, 8'hC0, 8'h79, 8'hF8, 8'hC0};
    localparam logic [47:0] D2  = {8'hF9, 8'h24, 8'hB0, 8'h79, 8'h90, 8'h90};
    localparam logic [47:0] DA  = {8'hF9, 8'h3F, 8'hBF, 8'h3F, 8'hC0, 8'hC0};
    localparam logic [47:0] BLK = {6{8'hFF}};

    always #5 clk = ~clk;

    date_display_seq #(
        .NUM_DATES      (3),
        .DATES          ({24'h051800, 24'h030170, 24'h123199}),
        .TICKS_PER_STEP (20),
        .DEBOUNCE_TICKS (4),
        .BLANK_TICKS    (3)
    ) dut (
        .MAX10_CLK1_50 (clk),
        .RST           (rst),
        .KEY           (key),
        .SW            (sw),
        .HEX0          (h0),
        .HEX1          (h1),
        .HEX2          (h2),
        .HEX3          (h3),
        .HEX4          (h4),
        .HEX5          (h5),
        .LEDR          (ledr)
    );

    // Second instance holds out-of-range nibbles to exercise the '-' glyph
    date_display_seq #(
        .NUM_DATES      (3),
        .DATES          ({24'h1AFA00, 24'h030170, 24'h123199}),
        .TICKS_PER_STEP (20),
        .DEBOUNCE_TICKS (4),
        .BLANK_TICKS    (3)
    ) dut_a (
        .MAX10_CLK1_50 (clk),
        .RST           (rst),
        .KEY           (2'b11),
        .SW            (2'b00),
        .HEX0          (a0),
        .HEX1          (a1),
        .HEX2          (a2),
        .HEX3          (a3),
        .HEX4          (a4),
        .HEX5          (a5),
        .LEDR          (ledr_a)
    );

    wire [47:0] hex   = {h5, h4, h3, h2, h1, h0};
    wire [47:0] hex_a = {a5, a4, a3, a2, a1, a0};

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        key = 2'b11;
        sw  = 2'b00;

        // Reset state and first displayed date
        tick(3);
        chk("reset_hex",  hex, BLK);
        chk("reset_ledr", {45'd0, ledr}, 48'd1);
        rst = 1'b0;
        tick(1);
        chk("date0_hex",  hex, D0);
        chk("date0_ledr", {45'd0, ledr}, 48'd1);
        chk("nibbleA_hex", hex_a, DA);

        // Next key held: index changes on edge 7, outputs one edge later
        key = 2'b01;
        tick(6);
        chk("next_e6_ledr", {45'd0, ledr}, 48'd1);
        tick(1);
        chk("next_e7_ledr", {45'd0, ledr}, 48'd1);
        chk("next_e7_hex",  hex, D0);
        tick(1);
        chk("next_e8_ledr", {45'd0, ledr}, 48'd2);
        chk("next_e8_blank", hex, BLK);
        tick(2);
        chk("next_e10_blank", hex, BLK);
        tick(1);
        chk("next_e11_hex", hex, D1);
        key = 2'b11;
        tick(10);
        chk("release_ledr", {45'd0, ledr}, 48'd2);
        chk("release_hex",  hex, D1);

        // Short glitch is rejected
        key = 2'b01;
        tick(3);
        key = 2'b11;
        tick(12);
        chk("glitch_ledr", {45'd0, ledr}, 48'd2);
        chk("glitch_hex",  hex, D1);

        // Prev from index 0 wraps to the last entry
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        chk("rst2_hex", hex, D0);
        key = 2'b10;
        tick(8);
        chk("prev_e8_ledr", {45'd0, ledr}, 48'd4);
        chk("prev_e8_blank", hex, BLK);
        tick(3);
        chk("prev_e11_hex", hex, D2);
        key = 2'b11;
        tick(10);

        // Next from the last entry wraps to 0; reset lands in the blank gap
        key = 2'b01;
        tick(8);
        chk("wrap_e8_ledr", {45'd0, ledr}, 48'd1);
        chk("wrap_e8_blank", hex, BLK);
        rst = 1'b1;
        key = 2'b11;
        tick(1);
        chk("rstblank_hex",  hex, BLK);
        chk("rstblank_ledr", {45'd0, ledr}, 48'd1);
        rst = 1'b0;
        tick(1);
        chk("rstblank_after_hex", hex, D0);

        // Auto-advance forward every 20 cycles
        sw = 2'b01;
        tick(20);
        chk("auto_e20_ledr", {45'd0, ledr}, 48'd1);
        tick(1);
        chk("auto_e21_ledr", {45'd0, ledr}, 48'd2);
        tick(19);
        chk("auto_e40_ledr", {45'd0, ledr}, 48'd2);
        tick(1);
        chk("auto_e41_ledr", {45'd0, ledr}, 48'd4);
        tick(20);
        chk("auto_e61_ledr", {45'd0, ledr}, 48'd1);

        // Reverse direction: 0 -> 2 -> 1
        sw = 2'b11;
        tick(20);
        chk("rev_e81_ledr", {45'd0, ledr}, 48'd4);
        tick(20);
        chk("rev_e101_ledr", {45'd0, ledr}, 48'd2);

        // Both keys in the same cycle: no change, auto counter restarts
        rst = 1'b1;
        sw  = 2'b00;
        tick(2);
        rst = 1'b0;
        sw  = 2'b01;
        key = 2'b00;
        tick(8);
        chk("both_e8_hex",  hex, D0);
        chk("both_e8_ledr", {45'd0, ledr}, 48'd1);
        key = 2'b11;
        tick(19);
        chk("both_e27_ledr", {45'd0, ledr}, 48'd1);
        tick(1);
        chk("both_e28_ledr", {45'd0, ledr}, 48'd2);
        sw = 2'b00;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/date_display_seq.md
Name: date_display_seq

Overview:
- Parametrised successor to the fixed two-date seven-segment display unit.
- Holds NUM_DATES six-digit BCD dates (MMDDYY) and shows one at a time on HEX5..HEX0, with MM.DD.YY decimal-point separators.
- KEY[1] steps forward and KEY[0] steps back, both debounced; SW[0] enables timed auto-advance.
- Every index change inserts a timed blank gap.

Parameters:
- NUM_DATES, 4: number of stored dates; minimum 2.
- DATES, {24'h051800, 24'h030170, 24'h123199, 24'h070400}: packed BCD dates; entry 0 in the most-significant 24 bits.
- TICKS_PER_STEP, 50000000: clock cycles between auto-advances.
- DEBOUNCE_TICKS, 500000: cycles a synchronised key must hold a new level before it is accepted.
- BLANK_TICKS, 5000000: cycles of blank display after an index change; minimum 1.

Ports:
- MAX10_CLK1_50  in   1  system clock.
- RST  in  1  synchronous, active-high reset.
- KEY  in  2  raw pushbuttons, active-low; KEY[1]=next, KEY[0]=prev.
- SW  in  2  SW[0]=auto-advance enable; SW[1]=reverse auto direction.
- HEX0..HEX5  out  8 each  segments {dp,g,f,e,d,c,b,a}, active-low; HEX5 is the leftmost digit.
- LEDR  out  NUM_DATES  one-hot current index, active-high.

Behaviour:
- Clock and reset: single clock MAX10_CLK1_50; RST is sampled only on the rising edge.
- Reset values:
  - index = 0; state = SHOW; all counters = 0.
  - Debounced key levels = 1; sync flops = 1.
  - All HEX = 8'hFF; LEDR = one-hot 0.
- Output latency: all outputs are registered and reflect state/index one cycle later. The first cycle after reset release shows date 0.
- Key path:
  - 2-flop synchroniser per key.
  - A per-key counter increments while the synced level differs from the debounced level, and clears otherwise.
  - When the counter reaches DEBOUNCE_TICKS-1, the debounced level flips.
  - A 1->0 flip of the debounced level produces a one-cycle press pulse; release produces no pulse.
  - A KEY that falls and stays low changes the index on edge DEBOUNCE_TICKS+3 after the first low sample.
  - Glitches shorter than DEBOUNCE_TICKS are ignored.
- Index update, evaluated each cycle in this priority:
  1. Next and prev pulses in the same cycle: no change; auto counter clears.
  2. Next pulse: index+1, wrapping NUM_DATES-1 -> 0.
  3. Prev pulse: index-1, wrapping 0 -> NUM_DATES-1.
  4. SW[0]=1 and auto counter = TICKS_PER_STEP-1: step +1, or -1 if SW[1]=1, with the same wrap rules.
- Auto counter:
  - Counts only while SW[0]=1.
  - Holds 0 while SW[0]=0.
  - Clears on any index change, including manual ones.
- FSM:
  - SHOW: display the current date. Any index change -> BLANK with the blank counter at 0.
  - BLANK: all HEX = 8'hFF. Exits to SHOW after BLANK_TICKS cycles.
  - A further index change during BLANK restarts the blank counter and stays in BLANK.
  - LEDR tracks the index immediately, in both states.
- Digit mapping:
  - HEX5/HEX4 = month tens/units; HEX3/HEX2 = day; HEX1/HEX0 = year.
  - DP is lit (bit7=0) on HEX4 and HEX2 only.
  - Segment codes with dp off: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
  - Any nibble >9 displays '-' = BF, with the dp rule still applied.
- Reset mid-operation: RST asserted during BLANK or mid-debounce returns immediately to the reset values. No pulse may be emitted from a partially debounced key.

Test Plan:
Bench parameters for all scenarios: NUM_DATES=3, DATES={051800,030170,123199}, TICKS_PER_STEP=20, DEBOUNCE_TICKS=4, BLANK_TICKS=3.
1. Reset then release, SW=0 -> HEX5..0 = C0,12,F9,00,C0,C0; LEDR=3'b001.
2. KEY[1] low and held -> index=1 on edge 7 after the first low sample.
   - HEX = FF for 3 cycles, then C0,30,C0,79,F8,C0; LEDR=3'b010.
3. KEY[1] low for 3 cycles, then high -> no index change, HEX unchanged.
4. At index 0, press KEY[0] -> wrap to index 2: after blank, HEX = F9,24,B0,79,90,90; LEDR=3'b100.
5. Auto-advance timing:
   - SW=2'b01 from index 0 -> index 1 after 20 cycles, index 2 after 40, index 0 after 60.
   - SW=2'b11 -> sequence 0->2->1.
6. Edge cases:
   - Both keys debounced in the same cycle -> index unchanged, auto counter cleared.
   - A nibble of 4'hA in a date -> that digit shows BF, or 3F on HEX4/HEX2.
   - RST during BLANK -> next cycle HEX=FF, then date 0.
